axis_packet_arbiter: RTL and testbench
======================================

# axis_packet_arbiter

Merges NUM_MASTER_STREAMS AXI-stream inputs into one output with packet-granular round-robin arbitration: once a source is granted, it keeps the output until its tlast beat is accepted. It is the merge stage that consumes the parallel streams produced by the round-robin splitter after per-lane processing, and recombines them onto a single stream. The output is registered through a two-entry skid buffer, so that stage sustains one beat per cycle under backpressure.

## Interface
Parameters:
- AXIS_BYTES, 1, tdata width in bytes on every stream
- NUM_MASTER_STREAMS, 2, number of input streams; legal range 2..16
- SRC_W, $clog2(NUM_MASTER_STREAMS), width of the source-index output (derived, not overridden)

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- areset  input  1  asynchronous, active-high reset
- axis_i_tready  output  NUM_MASTER_STREAMS  per-input ready
- axis_i_tvalid  input  NUM_MASTER_STREAMS  per-input valid
- axis_i_tlast  input  NUM_MASTER_STREAMS  per-input end of packet
- axis_i_tdata  input  NUM_MASTER_STREAMS*AXIS_BYTES*8  inputs concatenated; input k occupies bits [k*AXIS_BYTES*8 +: AXIS_BYTES*8]
- axis_o_tready  input  1  output ready
- axis_o_tvalid  output  1  output valid
- axis_o_tlast  output  1  output end of packet
- axis_o_tdata  output  AXIS_BYTES*8  output data
- axis_o_tsrc  output  SRC_W  index of the input that supplied the current output beat

## Operation
- Reset values of all outputs: axis_i_tready all 0, axis_o_tvalid 0, axis_o_tlast 0, axis_o_tdata 0, axis_o_tsrc 0. Internal reset values: state IDLE, priority pointer ptr 0, grant 0, skid buffer empty.
- Reset asserted mid-packet discards the packet in flight and any buffered beats. No partial beat is emitted after reset deasserts.
- States:
  - IDLE: every axis_i_tready is 0. If any tvalid is 1, the arbiter picks the first asserted input found by searching ptr, ptr+1, … with wrap modulo N. It registers that input into grant and moves to LOCKED. If no tvalid is 1, it stays in IDLE.
  - LOCKED: axis_i_tready[grant] equals the skid-buffer input ready; all other tready bits are 0. A beat is accepted when tvalid[grant] and tready[grant] are both 1. Accepting a beat with tlast=1 sets ptr to (grant+1) mod N and returns the state to IDLE.
- A tvalid gap on the granted input does not release the grant. The arbiter has no timeout.
- tvalid on an ungranted input is ignored. Those inputs stall, as AXI-stream allows.
- Each accepted beat enters the skid buffer with {tdata, tlast, grant}. axis_o_tsrc is the stored grant value.
- Skid buffer:
  - Two entries.
  - Input ready is registered and equals "not full".
  - Output is driven from the head register.
  - Data, tlast and tsrc are stable while tvalid=1 and tready=0.
- A simultaneous push and pop on a one-entry buffer leaves occupancy at 1.

## Timing
- Grant decision: 1 cycle in IDLE. The first beat of a packet is accepted at the earliest in the cycle after the IDLE decision.
- Latency: a beat accepted at edge n appears on axis_o_* from edge n+1.
- Throughput: 1 beat per cycle within a packet while axis_o_tready=1. Exactly one dead input cycle (the IDLE cycle) separates consecutive packets.
- axis_o_tready low for one or more cycles causes no data loss. Input tready falls no later than the edge at which the buffer becomes full.

## Structure
- Package axis_arb_pkg holds:
  - state enum (IDLE, LOCKED)
  - function next_rr(valid, ptr) returning the winning index
- Sub-module axis_skid_buffer: two-entry register slice, parameterised by payload width (AXIS_BYTES*8 + 1 + SRC_W). Reusable across the axis library.

## Test plan
- N=2, only input 0 sends a 3-beat packet 0x11,0x22,0x33 with axis_o_tready held at 1 -> output shows 0x11,0x22,0x33 with tlast on 0x33 and tsrc=0, first beat 2 cycles after tvalid rises.
- N=2, both inputs continuously valid with 2-beat packets (input 0: 0xA0,0xA1; input 1: 0xB0,0xB1) -> output packets alternate A,B,A,B, never interleaved within a packet, one gap cycle between packets.
- N=3, only inputs 0 and 2 valid, single-beat packets -> order 0,2,0,2. This checks ptr wrap from 2 to 0 and that idle input 1 is skipped.
- Random axis_o_tready (50%) with a 16-beat incrementing packet -> all 16 values arrive in order, none duplicated, and output payload is stable whenever tvalid=1 and tready=0.
- Granted input drops tvalid for 3 cycles mid-packet while input 1 is valid -> grant holds, and input 1 is served only after the tlast of input 0.
- areset pulsed after beat 2 of a 5-beat packet -> all outputs return to reset values immediately. After release the next packet starts cleanly from input 0, with no leftover beats.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// +----------------------------------------------------------------------------
// | axis_arb_pkg : shared types and round-robin helper for the AXIS arbiter
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package axis_arb_pkg;

  localparam int MAX_STREAMS = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // First asserted valid found searching ptr, ptr+1, ... modulo n.
  function automatic int unsigned next_rr(
    input logic [MAX_STREAMS-1:0] valid,
    input int unsigned            ptr,
    input int unsigned            n
  );
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_STREAMS; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// +----------------------------------------------------------------------------
// | axis_skid_buffer : two-entry register slice with registered input ready
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_push    = in_valid & r_ready;
  assign w_pop     = (r_count != 2'd0) & out_ready;
  assign in_ready  = r_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is computed from the next occupancy so it drops on the edge that fills.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
      r_ready <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_head <= r_tail;
        end else if (w_push) begin
          r_head <= in_data;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_head <= in_data;
        end else begin
          r_tail <= in_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
// +----------------------------------------------------------------------------
// | axis_packet_arbiter : packet-granular round-robin merge of N AXI streams
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXIS_BYTES         = 1,
  parameter int NUM_MASTER_STREAMS = 2,
  parameter int SRC_W              = $clog2(NUM_MASTER_STREAMS)
) (
  input  logic                                   clk,
  input  logic                                   areset,
  output logic [NUM_MASTER_STREAMS-1:0]          axis_i_tready,
  input  logic [NUM_MASTER_STREAMS-1:0]          axis_i_tvalid,
  input  logic [NUM_MASTER_STREAMS-1:0]          axis_i_tlast,
  input  logic [NUM_MASTER_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                                   axis_o_tready,
  output logic                                   axis_o_tvalid,
  output logic                                   axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]                axis_o_tdata,
  output logic [SRC_W-1:0]                       axis_o_tsrc
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int PW = DW + 1 + SRC_W;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [SRC_W-1:0]       r_ptr;
  logic [SRC_W-1:0]       w_ptr_nxt;
  logic [SRC_W-1:0]       r_grant;
  logic [SRC_W-1:0]       w_grant_nxt;
  logic [MAX_STREAMS-1:0] w_valid_pad;
  logic [SRC_W-1:0]       w_pick;
  logic                   w_sb_ready;
  logic                   w_sb_push;
  logic                   w_accept;
  logic [DW-1:0]          w_sel_data;
  logic [PW-1:0]          w_sb_in;
  logic [PW-1:0]          w_sb_out;

  always_comb begin
    w_valid_pad                           = '0;
    w_valid_pad[NUM_MASTER_STREAMS-1:0]   = axis_i_tvalid;
  end

  assign w_pick     = SRC_W'(next_rr(w_valid_pad, 32'(r_ptr), NUM_MASTER_STREAMS));
  assign w_sel_data = axis_i_tdata[32'(r_grant)*DW +: DW];
  assign w_sb_push  = (r_state == LOCKED) & axis_i_tvalid[r_grant];
  assign w_accept   = w_sb_push & w_sb_ready;
  assign w_sb_in    = {w_sel_data, axis_i_tlast[r_grant], r_grant};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    axis_i_tready = '0;
    case (r_state)
      IDLE: begin
        if (|axis_i_tvalid) begin
          w_grant_nxt = w_pick;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        axis_i_tready[r_grant] = w_sb_ready;
        // The grant is released only by an accepted tlast; valid gaps keep it.
        if (w_accept && axis_i_tlast[r_grant]) begin
          w_ptr_nxt   = SRC_W'((32'(r_grant) + 32'd1) % NUM_MASTER_STREAMS);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  axis_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (w_sb_push),
    .in_ready  (w_sb_ready),
    .in_data   (w_sb_in),
    .out_valid (axis_o_tvalid),
    .out_ready (axis_o_tready),
    .out_data  (w_sb_out)
  );

  assign axis_o_tdata = w_sb_out[PW-1 -: DW];
  assign axis_o_tlast = w_sb_out[SRC_W];
  assign axis_o_tsrc  = w_sb_out[SRC_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
// +----------------------------------------------------------------------------
// | tb_axis_packet_arbiter : directed bench for the packet arbiter (N=2, N=3)
// | rev 1.0
// +----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_packet_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  t2_valid, t2_last, t2_ready;
  logic [15:0] t2_data;
  logic        o2_ready, o2_valid, o2_last;
  logic [7:0]  o2_data;
  logic [0:0]  o2_src;

  logic [2:0]  t3_valid, t3_last, t3_ready;
  logic [23:0] t3_data;
  logic        o3_ready, o3_valid, o3_last;
  logic [7:0]  o3_data;
  logic [1:0]  o3_src;

  axis_packet_arbiter #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(2)) dut2 (
    .clk(clk), .areset(rst),
    .axis_i_tready(t2_ready), .axis_i_tvalid(t2_valid), .axis_i_tlast(t2_last),
    .axis_i_tdata(t2_data), .axis_o_tready(o2_ready), .axis_o_tvalid(o2_valid),
    .axis_o_tlast(o2_last), .axis_o_tdata(o2_data), .axis_o_tsrc(o2_src)
  );

  axis_packet_arbiter #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(3)) dut3 (
    .clk(clk), .areset(rst),
    .axis_i_tready(t3_ready), .axis_i_tvalid(t3_valid), .axis_i_tlast(t3_last),
    .axis_i_tdata(t3_data), .axis_o_tready(o3_ready), .axis_o_tvalid(o3_valid),
    .axis_o_tlast(o3_last), .axis_o_tdata(o3_data), .axis_o_tsrc(o3_src)
  );

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int m2_pay[128];
  int m2_cyc[128];
  int m2_cnt = 0;
  int m3_pay[64];
  int m3_cnt = 0;
  int n_stall = 0;
  int n_unstable = 0;
  logic prev_stall = 1'b0;
  int prev_pay = 0;

  function automatic int pk(input int src, input logic last, input logic [7:0] d);
    return src * 512 + (last ? 256 : 0) + int'(d);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted beats and payload stability while stalled.
  always @(negedge clk) begin
    if (o2_valid && o2_ready) begin
      m2_pay[m2_cnt] <= pk(int'(o2_src), o2_last, o2_data);
      m2_cyc[m2_cnt] <= cyc;
      m2_cnt         <= m2_cnt + 1;
    end
    if (prev_stall && !rst) begin
      n_stall <= n_stall + 1;
      if (!o2_valid || pk(int'(o2_src), o2_last, o2_data) != prev_pay)
        n_unstable <= n_unstable + 1;
    end
    prev_stall <= o2_valid && !o2_ready && !rst;
    prev_pay   <= pk(int'(o2_src), o2_last, o2_data);
    if (o3_valid && o3_ready) begin
      m3_pay[m3_cnt] <= pk(int'(o3_src), o3_last, o3_data);
      m3_cnt         <= m3_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input int d, input int k, input logic [7:0] v, input logic l);
    int   guard;
    logic ok;
    if (d == 2) begin
      t2_valid[k] = 1'b1; t2_data[k*8 +: 8] = v; t2_last[k] = l;
    end else begin
      t3_valid[k] = 1'b1; t3_data[k*8 +: 8] = v; t3_last[k] = l;
    end
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 300) begin
      @(negedge clk);
      ok = (d == 2) ? t2_ready[k] : t3_ready[k];
      @(posedge clk);
      #1;
      guard++;
    end
    if (d == 2) t2_valid[k] = 1'b0;
    else        t3_valid[k] = 1'b0;
    chk("in_handshake", int'(ok), 1);
  endtask

  task automatic wait_out(input int d, input int target);
    int g;
    g = 0;
    while (((d == 2) ? m2_cnt : m3_cnt) < target && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("out_drain", int'(((d == 2) ? m2_cnt : m3_cnt) >= target), 1);
  endtask

  task automatic do_reset();
    t2_valid = '0;
    t3_valid = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int rd, base, c0, s0, u0, src;
    rst = 1'b1;
    t2_valid = '0; t2_last = '0; t2_data = '0; o2_ready = 1'b1;
    t3_valid = '0; t3_last = '0; t3_data = '0; o3_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_i_tready", int'(t2_ready), 0);
    chk("rst_o_tvalid", int'(o2_valid), 0);
    chk("rst_o_tlast",  int'(o2_last), 0);
    chk("rst_o_tdata",  int'(o2_data), 0);
    chk("rst_o_tsrc",   int'(o2_src), 0);
    chk("rst3_o_tvalid", int'(o3_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single 3-beat packet from input 0.
    rd = m2_cnt;
    c0 = cyc;
    send_beat(2, 0, 8'h11, 1'b0);
    send_beat(2, 0, 8'h22, 1'b0);
    send_beat(2, 0, 8'h33, 1'b1);
    wait_out(2, rd + 3);
    chk("t1_beat0", m2_pay[rd],     pk(0, 1'b0, 8'h11));
    chk("t1_beat1", m2_pay[rd + 1], pk(0, 1'b0, 8'h22));
    chk("t1_beat2", m2_pay[rd + 2], pk(0, 1'b1, 8'h33));
    chk("t1_latency", m2_cyc[rd] - c0, 2);
    chk("t1_back2back", m2_cyc[rd + 2] - m2_cyc[rd], 2);

    // Both inputs continuously valid, 2-beat packets.
    do_reset();
    rd = m2_cnt;
    fork
      begin
        send_beat(2, 0, 8'hA0, 1'b0); send_beat(2, 0, 8'hA1, 1'b1);
        send_beat(2, 0, 8'hA0, 1'b0); send_beat(2, 0, 8'hA1, 1'b1);
      end
      begin
        send_beat(2, 1, 8'hB0, 1'b0); send_beat(2, 1, 8'hB1, 1'b1);
        send_beat(2, 1, 8'hB0, 1'b0); send_beat(2, 1, 8'hB1, 1'b1);
      end
    join
    wait_out(2, rd + 8);
    for (int i = 0; i < 8; i++) begin
      src = (i / 2) % 2;
      chk("t2_order", m2_pay[rd + i],
          pk(src, (i % 2) == 1, 8'((src == 1 ? 8'hB0 : 8'hA0) + (i % 2))));
    end
    chk("t2_gap", m2_cyc[rd + 2] - m2_cyc[rd + 1], 2);

    // N=3, inputs 0 and 2 only: pointer must skip 1 and wrap 2 -> 0.
    do_reset();
    rd = m3_cnt;
    fork
      begin send_beat(3, 0, 8'h01, 1'b1); send_beat(3, 0, 8'h03, 1'b1); end
      begin send_beat(3, 2, 8'h02, 1'b1); send_beat(3, 2, 8'h04, 1'b1); end
    join
    wait_out(3, rd + 4);
    chk("t3_first",  m3_pay[rd],     pk(0, 1'b1, 8'h01));
    chk("t3_second", m3_pay[rd + 1], pk(2, 1'b1, 8'h02));
    chk("t3_third",  m3_pay[rd + 2], pk(0, 1'b1, 8'h03));
    chk("t3_fourth", m3_pay[rd + 3], pk(2, 1'b1, 8'h04));

    // 16-beat packet under random output backpressure.
    do_reset();
    rd = m2_cnt;
    s0 = n_stall;
    u0 = n_unstable;
    fork
      begin
        for (int i = 0; i < 16; i++) send_beat(2, 0, 8'(8'h40 + i), i == 15);
      end
      begin
        int g;
        g = 0;
        while (m2_cnt < rd + 16 && g < 600) begin
          o2_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          g++;
        end
        o2_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("t4_count", m2_cnt - rd, 16);
    for (int i = 0; i < 16; i++)
      chk("t4_beat", m2_pay[rd + i], pk(0, i == 15, 8'(8'h40 + i)));
    chk("t4_stable", n_unstable - u0, 0);
    chk("t4_stall_seen", int'(n_stall > s0), 1);

    // Valid gap on the granted input must not release the grant.
    do_reset();
    rd = m2_cnt;
    fork
      begin
        send_beat(2, 0, 8'hC0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_beat(2, 0, 8'hC1, 1'b0);
        send_beat(2, 0, 8'hC2, 1'b1);
      end
      begin
        send_beat(2, 1, 8'hD0, 1'b1);
      end
    join
    wait_out(2, rd + 4);
    chk("t5_c0", m2_pay[rd],     pk(0, 1'b0, 8'hC0));
    chk("t5_c1", m2_pay[rd + 1], pk(0, 1'b0, 8'hC1));
    chk("t5_c2", m2_pay[rd + 2], pk(0, 1'b1, 8'hC2));
    chk("t5_d0", m2_pay[rd + 3], pk(1, 1'b1, 8'hD0));
    chk("t5_gap", m2_cyc[rd + 1] - m2_cyc[rd], 4);

    // Asynchronous reset in the middle of a 5-beat packet.
    do_reset();
    rd = m2_cnt;
    send_beat(2, 0, 8'h50, 1'b0);
    send_beat(2, 0, 8'h51, 1'b0);
    t2_valid[0] = 1'b1; t2_data[7:0] = 8'h52; t2_last[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_i_tready", int'(t2_ready), 0);
    chk("t6_o_tvalid", int'(o2_valid), 0);
    chk("t6_o_tlast",  int'(o2_last), 0);
    chk("t6_o_tdata",  int'(o2_data), 0);
    chk("t6_o_tsrc",   int'(o2_src), 0);
    t2_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = m2_cnt;
    chk("t6_pre_count", base - rd, 1);
    fork
      begin send_beat(2, 0, 8'h60, 1'b0); send_beat(2, 0, 8'h61, 1'b1); end
      begin send_beat(2, 1, 8'h70, 1'b1); end
    join
    wait_out(2, base + 3);
    chk("t6_f0", m2_pay[base],     pk(0, 1'b0, 8'h60));
    chk("t6_f1", m2_pay[base + 1], pk(0, 1'b1, 8'h61));
    chk("t6_g0", m2_pay[base + 2], pk(1, 1'b1, 8'h70));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
